// File: rtl/tlm_collect_pkg.sv
// Shared types and constants for the TLM result collector and its storage banks.
package tlm_collect_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam int CSUM_W = 16;

endpackage

// File: rtl/tlm_result_bank.sv
// One ping-pong storage bank: item storage, fill state, closed count, and
// an optional running checksum (RESULT_CSUM_EN).
module tlm_result_bank
  import tlm_collect_pkg::*;
#(
  parameter int NUM        = 100,
  parameter int ITEM_WIDTH = 8,
  parameter int CNT_W      = $clog2(NUM+1)
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      wr_en,
  input  logic [CNT_W-1:0]          wr_idx,
  input  logic [ITEM_WIDTH-1:0]     wr_data,
  input  logic                      close,
  input  logic [CNT_W-1:0]          close_cnt,
  input  logic                      clear,
  output bank_state_e               state,
  output logic [CNT_W-1:0]          cnt,
  output logic [NUM*ITEM_WIDTH-1:0] data
`ifdef RESULT_CSUM_EN
  ,
  output logic [CSUM_W-1:0]         csum
`endif
);

  logic [NUM-1:0][ITEM_WIDTH-1:0] mem;
  bank_state_e                    state_nxt;

  assign data = mem;

  always_comb begin
    state_nxt = state;
    if (clear)
      state_nxt = BANK_EMPTY;
    else if (close)
      state_nxt = BANK_FULL;
    else if (wr_en && state == BANK_EMPTY)
      state_nxt = BANK_FILLING;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= BANK_EMPTY;
    else           state <= state_nxt;
  end

  // Clearing zeroes the bank so unused slots of a later partial batch read 0.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mem <= '0;
      cnt <= '0;
    end else if (clear) begin
      mem <= '0;
      cnt <= '0;
    end else begin
      for (int k = 0; k < NUM; k++)
        if (wr_en && wr_idx == CNT_W'(k)) mem[k] <= wr_data;
      if (close) cnt <= close_cnt;
    end
  end

`ifdef RESULT_CSUM_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)   csum <= '0;
    else if (clear)  csum <= '0;
    else if (wr_en)  csum <= csum + CSUM_W'(wr_data);
  end
`endif

endmodule

// File: rtl/tlm_result_collector.sv
// Ping-pong batch collector for the BFM result stream. Optional per-batch
// checksum output when RESULT_CSUM_EN is defined.
module tlm_result_collector
  import tlm_collect_pkg::*;
#(
  parameter int NUM        = 100,
  parameter int ITEM_WIDTH = 8,
  parameter int CNT_W      = $clog2(NUM+1)
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [ITEM_WIDTH-1:0]     res_i,
  input  logic                      res_vld_i,
  input  logic                      flush_i,
  output logic                      batch_rdy_o,
  output logic [NUM*ITEM_WIDTH-1:0] batch_data_o,
  output logic [CNT_W-1:0]          batch_cnt_o,
  input  logic                      batch_ack_i,
  output logic                      ovf_o
`ifdef RESULT_CSUM_EN
  ,
  output logic [CSUM_W-1:0]         batch_csum_o
`endif
);

  logic                                wr_bank, rd_bank;
  logic [CNT_W-1:0]                    wr_idx;
  bank_state_e                         st [2];
  logic [1:0][CNT_W-1:0]               bcnt;
  logic [1:0][NUM*ITEM_WIDTH-1:0]      bdata;
`ifdef RESULT_CSUM_EN
  logic [1:0][CSUM_W-1:0]              bcsum;
`endif

  logic             accept, last, close, ack_fire;
  logic [CNT_W-1:0] close_cnt;

  assign accept    = res_vld_i && (st[wr_bank] != BANK_FULL);
  assign last      = accept && (wr_idx == CNT_W'(NUM-1));
  // A flush only closes a bank that already holds items; a same-cycle
  // item on such a bank is folded into the closing batch.
  assign close     = last || (flush_i && wr_idx != '0);
  assign close_cnt = wr_idx + CNT_W'(accept);
  assign ack_fire  = batch_ack_i && batch_rdy_o;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tlm_result_bank #(
      .NUM       (NUM),
      .ITEM_WIDTH(ITEM_WIDTH),
      .CNT_W     (CNT_W)
    ) u_bank (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .wr_en    (accept && (wr_bank == 1'(b))),
      .wr_idx   (wr_idx),
      .wr_data  (res_i),
      .close    (close && (wr_bank == 1'(b))),
      .close_cnt(close_cnt),
      .clear    (ack_fire && (rd_bank == 1'(b))),
      .state    (st[b]),
      .cnt      (bcnt[b]),
      .data     (bdata[b])
`ifdef RESULT_CSUM_EN
      ,
      .csum     (bcsum[b])
`endif
    );
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      ovf_o   <= 1'b0;
    end else begin
      if (close) begin
        wr_bank <= ~wr_bank;
        wr_idx  <= '0;
      end else if (accept) begin
        wr_idx  <= wr_idx + CNT_W'(1);
      end
      if (ack_fire)               rd_bank <= ~rd_bank;
      if (res_vld_i && !accept)   ovf_o   <= 1'b1;
    end
  end

  // Outputs are gated so a bank still filling on the read side is never exposed.
  assign batch_rdy_o  = (st[rd_bank] == BANK_FULL);
  assign batch_data_o = batch_rdy_o ? bdata[rd_bank] : '0;
  assign batch_cnt_o  = batch_rdy_o ? bcnt[rd_bank]  : '0;
`ifdef RESULT_CSUM_EN
  assign batch_csum_o = batch_rdy_o ? bcsum[rd_bank] : '0;
`endif

endmodule

// File: tb/tb_tlm_result_collector.sv
// Self-checking bench for tlm_result_collector at NUM=4, ITEM_WIDTH=8,
// with a queue-based batch model. Checksum checks follow RESULT_CSUM_EN.
module tb_tlm_result_collector;
  localparam int NUM = 4;
  localparam int IW  = 8;
  localparam int CW  = 3;

  logic              clk_i = 1'b0;
  logic              reset_ni = 1'b0;
  logic [IW-1:0]     res_i = '0;
  logic              res_vld_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              batch_rdy_o;
  logic [NUM*IW-1:0] batch_data_o;
  logic [CW-1:0]     batch_cnt_o;
  logic              batch_ack_i = 1'b0;
  logic              ovf_o;
`ifdef RESULT_CSUM_EN
  logic [15:0]       batch_csum_o;
`endif

  tlm_result_collector #(.NUM(NUM), .ITEM_WIDTH(IW)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .res_i       (res_i),
    .res_vld_i   (res_vld_i),
    .flush_i     (flush_i),
    .batch_rdy_o (batch_rdy_o),
    .batch_data_o(batch_data_o),
    .batch_cnt_o (batch_cnt_o),
    .batch_ack_i (batch_ack_i),
    .ovf_o       (ovf_o)
`ifdef RESULT_CSUM_EN
    ,
    .batch_csum_o(batch_csum_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: closed batches waiting for the consumer (at most two,
  // one per bank) plus the items of the batch currently being collected.
  typedef struct {
    logic [NUM*IW-1:0] data;
    int                cnt;
    logic [15:0]       csum;
  } batch_t;
  batch_t       bq[$];
  logic [IW-1:0] cur[$];
  bit           m_ovf;

  function automatic void model_clear();
    bq.delete(); cur.delete(); m_ovf = 0;
  endfunction

  function automatic void model_step(bit v, logic [IW-1:0] d, bit f, bit a);
    bit acc  = v && bq.size() < 2;
    bit fire = a && bq.size() > 0;
    int pre  = cur.size();
    batch_t nb;
    if (v && !acc) m_ovf = 1;
    if (fire) void'(bq.pop_front());
    if (acc) cur.push_back(d);
    if (cur.size() == NUM || (f && pre > 0)) begin
      nb.data = '0; nb.cnt = cur.size(); nb.csum = '0;
      foreach (cur[i]) begin
        nb.data[i*IW +: IW] = cur[i];
        nb.csum += 16'(cur[i]);
      end
      bq.push_back(nb);
      cur.delete();
    end
  endfunction

  function automatic logic              e_rdy();  return bq.size() > 0; endfunction
  function automatic logic [NUM*IW-1:0] e_data(); return bq.size() > 0 ? bq[0].data : '0; endfunction
  function automatic logic [CW-1:0]     e_cnt();  return bq.size() > 0 ? CW'(bq[0].cnt) : '0; endfunction
  function automatic logic [15:0]       e_csum(); return bq.size() > 0 ? bq[0].csum : '0; endfunction

  // Drives one cycle of stimulus, advances the model, returns at posedge+1.
  task automatic step(input bit v, input logic [IW-1:0] d, input bit f, input bit a);
    res_vld_i = v; res_i = d; flush_i = f; batch_ack_i = a;
    model_step(v, d, f, a);
    @(posedge clk_i); #1;
    res_vld_i = 0; flush_i = 0; batch_ack_i = 0;
  endtask

  task automatic do_reset();
    reset_ni = 0;
    model_clear();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); reset_ni = 1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (batch_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", batch_rdy_o); end
    checks++; if (batch_data_o !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", batch_data_o); end
    checks++; if (batch_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", batch_cnt_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_o); end
  endtask

  task automatic test_full_batch();
    for (int i = 1; i <= 4; i++) step(1, IW'(i), 0, 0);
    checks++; if (batch_rdy_o !== 1'b1) begin errors++; $display("FAIL full_rdy got %b exp 1", batch_rdy_o); end
    checks++; if (batch_data_o !== 32'h04030201) begin errors++; $display("FAIL full_data got %h exp 04030201", batch_data_o); end
    checks++; if (batch_cnt_o !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", batch_cnt_o); end
`ifdef RESULT_CSUM_EN
    checks++; if (batch_csum_o !== 16'h000A) begin errors++; $display("FAIL full_csum got %h exp 000a", batch_csum_o); end
`endif
    step(0, 0, 0, 0);
    checks++; if (batch_data_o !== 32'h04030201) begin errors++; $display("FAIL full_hold got %h exp 04030201", batch_data_o); end
    step(0, 0, 0, 1);
    checks++; if (batch_rdy_o !== 1'b0) begin errors++; $display("FAIL full_ack_rdy got %b exp 0", batch_rdy_o); end
  endtask

  task automatic test_stream();
    int hi = 0, nb = 0;
    bit ack;
    logic [NUM*IW-1:0] exp;
    for (int c = 0; c < 20; c++) begin
      ack = (hi == 2);
      if (ack) begin
        for (int k = 0; k < NUM; k++) exp[k*IW +: IW] = IW'(4*nb + k);
        checks++; if (batch_data_o !== exp) begin errors++; $display("FAIL stream_batch%0d got %h exp %h", nb, batch_data_o, exp); end
        nb++;
      end
      step(c < 12, IW'(c), 0, ack);
      checks++; if (batch_rdy_o !== e_rdy()) begin errors++; $display("FAIL stream_rdy c%0d got %b exp %b", c, batch_rdy_o, e_rdy()); end
      hi = ack ? int'(batch_rdy_o) : (batch_rdy_o ? hi + 1 : 0);
    end
    checks++; if (nb != 3) begin errors++; $display("FAIL stream_count got %0d exp 3", nb); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b exp 0", ovf_o); end
  endtask

  task automatic test_flush();
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(0, 0, 1, 0);
    checks++; if (batch_cnt_o !== 3'd2) begin errors++; $display("FAIL flush_cnt got %0d exp 2", batch_cnt_o); end
    checks++; if (batch_data_o !== 32'h00002211) begin errors++; $display("FAIL flush_data got %h exp 00002211", batch_data_o); end
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    checks++; if (batch_rdy_o !== 1'b0) begin errors++; $display("FAIL flush_empty_rdy got %b exp 0", batch_rdy_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) step(1, IW'(i), 0, 0);
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf_o); end
    checks++; if (batch_data_o !== 32'h03020100) begin errors++; $display("FAIL ovf_bank0 got %h exp 03020100", batch_data_o); end
    step(0, 0, 0, 1);
    checks++; if (batch_data_o !== 32'h07060504) begin errors++; $display("FAIL ovf_bank1 got %h exp 07060504", batch_data_o); end
    step(0, 0, 0, 1);
    checks++; if (batch_rdy_o !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", batch_rdy_o); end
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_o); end
  endtask

  task automatic test_reset_mid();
    step(1, 8'hAA, 0, 0);
    step(1, 8'hBB, 0, 0);
    reset_ni = 0;
    model_clear();
    #1;
    checks++; if (batch_rdy_o !== 1'b0) begin errors++; $display("FAIL rstmid_rdy got %b exp 0", batch_rdy_o); end
    checks++; if (batch_data_o !== '0) begin errors++; $display("FAIL rstmid_data got %h exp 0", batch_data_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b exp 0", ovf_o); end
    @(negedge clk_i); reset_ni = 1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) step(1, IW'(8'h50 + i), 0, 0);
    checks++; if (batch_data_o !== 32'h53525150) begin errors++; $display("FAIL rstmid_batch got %h exp 53525150", batch_data_o); end
    checks++; if (batch_cnt_o !== 3'd4) begin errors++; $display("FAIL rstmid_cnt got %0d exp 4", batch_cnt_o); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_ack_overlap();
    for (int i = 0; i < 7; i++) step(1, IW'(i), 0, 0);
    step(1, 8'h07, 0, 1);
    checks++; if (batch_rdy_o !== 1'b1) begin errors++; $display("FAIL overlap_rdy got %b exp 1", batch_rdy_o); end
    checks++; if (batch_data_o !== 32'h07060504) begin errors++; $display("FAIL overlap_data got %h exp 07060504", batch_data_o); end
    step(0, 0, 0, 1);
    checks++; if (batch_rdy_o !== 1'b0) begin errors++; $display("FAIL overlap_drained got %b exp 0", batch_rdy_o); end
  endtask

  task automatic test_random();
    bit v, f, a;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 9) < 3);
      step(v, IW'($urandom), f, a);
      checks++;
      if (batch_rdy_o !== e_rdy() || batch_data_o !== e_data() || batch_cnt_o !== e_cnt() || ovf_o !== m_ovf
`ifdef RESULT_CSUM_EN
          || batch_csum_o !== e_csum()
`endif
         ) begin
        errors++;
        $display("FAIL random c%0d got rdy=%b data=%h cnt=%0d ovf=%b exp rdy=%b data=%h cnt=%0d ovf=%b",
                 c, batch_rdy_o, batch_data_o, batch_cnt_o, ovf_o, e_rdy(), e_data(), e_cnt(), m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_stream();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_ack_overlap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
